// File: rtl/inst_buffer_gen2.sv
// -----------------------------------------------------------------------------
// inst_buffer_gen2
// Decoupling queue between decode and rename. Up to FETCH_WIDTH decoded packets
// arrive each cycle on a sparse lane-valid vector. They are packed contiguously
// into a circular buffer. Up to DISPATCH_WIDTH of the oldest packets are
// presented to rename. Read lanes without a valid packet are forced to zero.
//
// Ports
//   clk              clock
//   reset            synchronous, active-high reset
//   flush_i          misprediction flush; empties the queue, drops same-cycle
//                    write and dispatch
//   stall_i          rename cannot accept this cycle
//   wr_valid_i       decode group valid
//   wr_vec_i         per-lane write valid (may be sparse)
//   wr_pkt_i         write packets, lane i at [i*PKT_W +: PKT_W]
//   stall_fetch_o    queue cannot guarantee room for a full fetch group
//   rd_vec_o         per-lane read valid, thermometer from lane 0
//   rd_pkt_o         read packets, lane j = entry head+j, zero when invalid
//   rd_ready_o       at least DISPATCH_WIDTH entries are held
//   branch_count_o   number of valid read lanes with the branch flag set
//   count_o          occupied entries
// -----------------------------------------------------------------------------
module inst_buffer_gen2 #(
  parameter int FETCH_WIDTH      = 8,
  parameter int DISPATCH_WIDTH   = 4,
  parameter int DEPTH            = 32,
  parameter int PKT_W            = 96,
  parameter int BR_BIT           = 80,
  parameter int PARTIAL_DISPATCH = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush_i,
  input  logic                                  stall_i,
  input  logic                                  wr_valid_i,
  input  logic [FETCH_WIDTH-1:0]                wr_vec_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0]          wr_pkt_i,
  output logic                                  stall_fetch_o,
  output logic [DISPATCH_WIDTH-1:0]             rd_vec_o,
  output logic [DISPATCH_WIDTH*PKT_W-1:0]       rd_pkt_o,
  output logic                                  rd_ready_o,
  output logic [$clog2(DISPATCH_WIDTH+1)-1:0]   branch_count_o,
  output logic [$clog2(DEPTH):0]                count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DISPATCH_WIDTH + 1);
  localparam int FW = $clog2(FETCH_WIDTH + 1);

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  // Storage is deliberately left out of reset; head/tail/count define validity.
  logic [PKT_W-1:0] mem_q [DEPTH];

  logic             acc;
  logic [FW-1:0]    prefix [FETCH_WIDTH+1];
  logic [AW-1:0]    waddr [FETCH_WIDTH];
  logic [FW-1:0]    n_w;
  logic [BW-1:0]    avail;
  logic [BW-1:0]    n_r;
  logic [BW-1:0]    n_d;
  logic             fire;
  logic [DISPATCH_WIDTH-1:0] br_bits;
  logic [BW-1:0]    branch_sum;

  // ---------------------------------------------------------------------------
  // Write side: accept and compaction
  // ---------------------------------------------------------------------------
  assign stall_fetch_o = count_q > CW'(DEPTH - FETCH_WIDTH);
  assign acc           = wr_valid_i & ~stall_fetch_o & ~flush_i;

  // prefix[i] = number of valid lanes below lane i, i.e. the slot offset that
  // lane i lands on relative to tail. prefix[FETCH_WIDTH] is the popcount.
  assign prefix[0] = '0;
  generate
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_wr
      assign prefix[gi+1] = prefix[gi] + FW'(wr_vec_i[gi]);
      assign waddr[gi]    = tail_q + AW'(prefix[gi]);
    end
  endgenerate

  assign n_w = acc ? prefix[FETCH_WIDTH] : '0;

  // Valid lanes always map to distinct addresses, so write ports never collide.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (acc && wr_vec_i[i]) begin
        mem_q[waddr[i]] <= wr_pkt_i[i*PKT_W +: PKT_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: group size, masking and branch count
  // ---------------------------------------------------------------------------
  assign rd_ready_o = count_q >= CW'(DISPATCH_WIDTH);
  assign avail      = rd_ready_o ? BW'(DISPATCH_WIDTH) : BW'(count_q);

  generate
    if (PARTIAL_DISPATCH != 0) begin : g_partial
      assign n_r = avail;
    end else begin : g_full_only
      assign n_r = rd_ready_o ? BW'(DISPATCH_WIDTH) : '0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_rd
      logic [PKT_W-1:0] lane_pkt;
      assign rd_vec_o[gi] = BW'(gi) < n_r;
      assign lane_pkt     = mem_q[head_q + AW'(gi)];
      assign rd_pkt_o[gi*PKT_W +: PKT_W] = rd_vec_o[gi] ? lane_pkt : '0;
      assign br_bits[gi]  = rd_vec_o[gi] & lane_pkt[BR_BIT];
    end
  endgenerate

  always_comb begin
    branch_sum = '0;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      branch_sum = branch_sum + BW'(br_bits[j]);
    end
  end
  assign branch_count_o = branch_sum;

  // ---------------------------------------------------------------------------
  // Pointer / occupancy update
  // ---------------------------------------------------------------------------
  assign fire = ~stall_i & ~flush_i & (n_r != '0);
  assign n_d  = fire ? n_r : '0;

  // Writes only occur when count <= DEPTH-FETCH_WIDTH and reads never exceed
  // count, so the net update stays within [0, DEPTH].
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(n_d);
      tail_d  = tail_q + AW'(n_w);
      count_d = count_q + CW'(n_w) - CW'(n_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_inst_buffer_gen2.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer_gen2
// Directed bench for inst_buffer_gen2. u_dut uses default parameters; u_part
// uses PARTIAL_DISPATCH=1 and shares reset, flush and write data with u_dut but
// has its own write-valid and stall so it stays idle until the partial phase.
// -----------------------------------------------------------------------------
module tb_inst_buffer_gen2;

  localparam int FW = 8;
  localparam int DW = 4;
  localparam int PW = 96;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            stall, p_stall;
  logic            wr_valid, p_wr_valid;
  logic [FW-1:0]   wr_vec;
  logic [FW*PW-1:0] wr_pkt;

  logic            stall_fetch, p_stall_fetch;
  logic [DW-1:0]   rd_vec, p_rd_vec;
  logic [DW*PW-1:0] rd_pkt, p_rd_pkt;
  logic            rd_ready, p_rd_ready;
  logic [2:0]      br_cnt, p_br_cnt;
  logic [5:0]      count, p_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_buffer_gen2 u_dut (
    .clk(clk), .reset(reset), .flush_i(flush), .stall_i(stall),
    .wr_valid_i(wr_valid), .wr_vec_i(wr_vec), .wr_pkt_i(wr_pkt),
    .stall_fetch_o(stall_fetch), .rd_vec_o(rd_vec), .rd_pkt_o(rd_pkt),
    .rd_ready_o(rd_ready), .branch_count_o(br_cnt), .count_o(count)
  );

  inst_buffer_gen2 #(.PARTIAL_DISPATCH(1)) u_part (
    .clk(clk), .reset(reset), .flush_i(flush), .stall_i(p_stall),
    .wr_valid_i(p_wr_valid), .wr_vec_i(wr_vec), .wr_pkt_i(wr_pkt),
    .stall_fetch_o(p_stall_fetch), .rd_vec_o(p_rd_vec), .rd_pkt_o(p_rd_pkt),
    .rd_ready_o(p_rd_ready), .branch_count_o(p_br_cnt), .count_o(p_count)
  );

  function automatic logic [PW-1:0] pk(input int v, input bit br);
    logic [PW-1:0] r;
    r = PW'(v);
    r[80] = br;
    return r;
  endfunction

  function automatic logic [DW*PW-1:0] grp(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                            input logic [PW-1:0] c, input logic [PW-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [DW*PW-1:0] obs, input logic [DW*PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_lanes(input int base);
    for (int i = 0; i < FW; i++) wr_pkt[i*PW +: PW] = pk(base + i, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; p_stall = 1'b1;
    wr_valid = 1'b0; p_wr_valid = 1'b0; wr_vec = '0; wr_pkt = '0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_stall_fetch", stall_fetch, 0);
    chk("rst_rd_vec", rd_vec, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_branch", br_cnt, 0);
    chk("rst_rd_pkt", rd_pkt, 0);
    $display("txn reset: count=%0d rd_vec=%b", count, rd_vec);

    // Fill and drain
    wr_valid = 1'b1; wr_vec = 8'hFF; load_lanes(0);
    step();
    wr_valid = 1'b0;
    chk("fill_count", count, 8);
    chk("fill_rd_vec", rd_vec, 4'b1111);
    chk("fill_rd_ready", rd_ready, 1);
    chk("fill_pkts", rd_pkt, grp(pk(0,0), pk(1,0), pk(2,0), pk(3,0)));
    $display("txn fill: count=%0d rd_vec=%b", count, rd_vec);
    step();
    chk("drain1_count", count, 4);
    chk("drain1_pkts", rd_pkt, grp(pk(4,0), pk(5,0), pk(6,0), pk(7,0)));
    $display("txn drain1: count=%0d", count);
    step();
    chk("drain2_count", count, 0);
    chk("drain2_rd_vec", rd_vec, 0);
    $display("txn drain2: count=%0d rd_vec=%b", count, rd_vec);

    // Compaction of a sparse write
    wr_valid = 1'b1; wr_vec = 8'b1010_0101; load_lanes(0);
    step();
    wr_valid = 1'b0;
    chk("compact_count", count, 4);
    chk("compact_pkts", rd_pkt, grp(pk(0,0), pk(2,0), pk(5,0), pk(7,0)));
    $display("txn compact: count=%0d", count);
    step();
    chk("compact_drain", count, 0);
    $display("txn compact_drain: count=%0d", count);

    // Full and backpressure
    stall = 1'b1; wr_valid = 1'b1; wr_vec = 8'hFF; load_lanes(100);
    step(); chk("full_8", count, 8);
    step(); chk("full_16", count, 16);
    step(); chk("full_24", count, 24);
    chk("full_sf_at24", stall_fetch, 0);
    step(); chk("full_32", count, 32);
    chk("full_sf_at32", stall_fetch, 1);
    step(); chk("full_hold_32", count, 32);
    chk("full_hold_pkts", rd_pkt, grp(pk(100,0), pk(101,0), pk(102,0), pk(103,0)));
    $display("txn full: count=%0d stall_fetch=%0d", count, stall_fetch);
    stall = 1'b0; wr_valid = 1'b0;
    step(); chk("release_28", count, 28);
    chk("release_sf_28", stall_fetch, 1);
    chk("release_pkts_28", rd_pkt, grp(pk(104,0), pk(105,0), pk(106,0), pk(107,0)));
    step(); chk("release_24", count, 24);
    chk("release_sf_24", stall_fetch, 0);
    $display("txn release: count=%0d stall_fetch=%0d", count, stall_fetch);

    // Flush to zero, then move head/tail to 28
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", count, 0);
    stall = 1'b1; wr_valid = 1'b1; wr_vec = 8'hFF; load_lanes(200);
    step(); step(); step();
    wr_vec = 8'h0F;
    step();
    chk("advance_28", count, 28);
    wr_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("advance_empty", count, 0);
    $display("txn advance: count=%0d", count);

    // Wrap-around write of A..H starting at entry 28
    stall = 1'b1; wr_valid = 1'b1; wr_vec = 8'hFF; load_lanes(32'hA0);
    step();
    wr_valid = 1'b0;
    chk("wrap_count", count, 8);
    chk("wrap_pkts_lo", rd_pkt, grp(pk(32'hA0,0), pk(32'hA1,0), pk(32'hA2,0), pk(32'hA3,0)));
    stall = 1'b0;
    step();
    chk("wrap_pkts_hi", rd_pkt, grp(pk(32'hA4,0), pk(32'hA5,0), pk(32'hA6,0), pk(32'hA7,0)));
    chk("wrap_count_4", count, 4);
    step();
    chk("wrap_empty", count, 0);
    $display("txn wrap: count=%0d", count);

    // Branch count in lanes 1 and 3
    stall = 1'b1; wr_valid = 1'b1; wr_vec = 8'h0F;
    wr_pkt = '0;
    wr_pkt[0*PW +: PW] = pk(10, 0);
    wr_pkt[1*PW +: PW] = pk(11, 1);
    wr_pkt[2*PW +: PW] = pk(12, 0);
    wr_pkt[3*PW +: PW] = pk(13, 1);
    step();
    wr_valid = 1'b0;
    chk("branch_count", br_cnt, 2);
    $display("txn branch: branch_count=%0d", br_cnt);

    // Flush together with a write and a dispatch
    flush = 1'b1; stall = 1'b0; wr_valid = 1'b1; wr_vec = 8'hFF; load_lanes(32'hE0);
    step();
    flush = 1'b0; wr_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_rd_vec", rd_vec, 0);
    step();
    chk("flush_count_after", count, 0);
    chk("flush_no_ghost", rd_pkt, 0);
    $display("txn flush: count=%0d rd_vec=%b", count, rd_vec);

    // Partial mode: three packets held in both instances
    stall = 1'b0; p_stall = 1'b1;
    wr_valid = 1'b1; p_wr_valid = 1'b1; wr_vec = 8'h07;
    wr_pkt = '0;
    wr_pkt[0*PW +: PW] = pk(50, 0);
    wr_pkt[1*PW +: PW] = pk(51, 1);
    wr_pkt[2*PW +: PW] = pk(52, 0);
    step();
    wr_valid = 1'b0; p_wr_valid = 1'b0;
    chk("full_only_count3", count, 3);
    chk("full_only_rd_vec", rd_vec, 0);
    chk("full_only_rd_ready", rd_ready, 0);
    chk("full_only_branch", br_cnt, 0);
    chk("full_only_pkts", rd_pkt, 0);
    chk("partial_count3", p_count, 3);
    chk("partial_rd_vec", p_rd_vec, 4'b0111);
    chk("partial_rd_ready", p_rd_ready, 0);
    chk("partial_branch", p_br_cnt, 1);
    chk("partial_pkts", p_rd_pkt, grp(pk(50,0), pk(51,1), pk(52,0), '0));
    p_stall = 1'b0;
    step();
    chk("full_only_hold3", count, 3);
    chk("partial_drained", p_count, 0);
    chk("partial_rd_vec_0", p_rd_vec, 0);
    $display("txn partial: full_only_count=%0d partial_count=%0d", count, p_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
